// File: rtl/store_buffer_if.sv
// store_buffer_if: store, load-probe and memory-write signals of the store buffer
// Parameters: ADDR_W byte-address width, DEPTH buffer entries (sizes count)
// Signals:
//   st_valid/st_addr/st_data/st_wstrb -> store request from the LSU, st_ready <- accept
//   ld_valid/ld_addr                   -> load in MEM stage, ld_stall <- pending-store hit
//   mem_req/mem_addr/mem_wdata/mem_wstrb <- head write to DRAM, mem_gnt -> accepted
//   empty/count                        <- occupancy status
// Modports: slave = the buffer, master = the LSU/memory side driving it.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    logic                      st_valid;
    logic [ADDR_W-1:0]         st_addr;
    logic [31:0]               st_data;
    logic [3:0]                st_wstrb;
    logic                      st_ready;
    logic                      ld_valid;
    logic [ADDR_W-1:0]         ld_addr;
    logic                      ld_stall;
    logic                      mem_req;
    logic [ADDR_W-1:0]         mem_addr;
    logic [31:0]               mem_wdata;
    logic [3:0]                mem_wstrb;
    logic                      mem_gnt;
    logic                      empty;
    logic [$clog2(DEPTH):0]    count;

    modport slave (
        input  st_valid, st_addr, st_data, st_wstrb, ld_valid, ld_addr, mem_gnt,
        output st_ready, ld_stall, mem_req, mem_addr, mem_wdata, mem_wstrb, empty, count
    );

    modport master (
        output st_valid, st_addr, st_data, st_wstrb, ld_valid, ld_addr, mem_gnt,
        input  st_ready, ld_stall, mem_req, mem_addr, mem_wdata, mem_wstrb, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the LSU and the DRAM write port
// Queues byte-laned stores and drains one per grant; loads hitting a pending word stall.
// Parameters: DEPTH entries (power of two, >=2), ADDR_W byte-address width.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset, discards all entries
//   sb   store_buffer_if.slave (store in, load probe, memory write out, empty/count)
// Optional feature: define STORE_BUF_COALESCE_EN to merge a store into the youngest
// entry when both hit the same word.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input logic           clk,
    input logic           rst,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = ADDR_W - 2;

    logic [TW-1:0]    tag_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       strb_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    rd_idx;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             merge;
    logic [TW-1:0]    st_tag;
    logic [TW-1:0]    ld_tag;
    logic [DEPTH-1:0] hit;
    logic             unused_lsb;

    assign wr_idx     = wr_ptr[PW-1:0];
    assign rd_idx     = rd_ptr[PW-1:0];
    assign st_tag     = sb.st_addr[ADDR_W-1:2];
    assign ld_tag     = sb.ld_addr[ADDR_W-1:2];
    assign unused_lsb = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

    // Pointers carry an extra wrap bit: equal means empty, differing only in it means full.
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}};
    assign pop   = !empty && sb.mem_gnt;
    // A merging store updates an existing entry and never allocates.
    assign push  = sb.st_valid && sb.st_ready && !merge;

`ifdef STORE_BUF_COALESCE_EN
    logic [PW-1:0] last_idx;
    logic [31:0]   merged;

    assign last_idx = wr_idx - PW'(1);
    // The youngest entry is off-limits while it is also the head leaving this cycle.
    assign merge = sb.st_valid && !empty && tag_q[last_idx] == st_tag &&
                   !(pop && last_idx == rd_idx);
    assign sb.st_ready = !full || merge;

    always_comb begin
        merged = data_q[last_idx];
        for (int b = 0; b < 4; b++)
            merged[8*b +: 8] = sb.st_wstrb[b] ? sb.st_data[8*b +: 8] : data_q[last_idx][8*b +: 8];
    end
`else
    assign merge       = 1'b0;
    // Deliberately ignores a same-cycle pop so ready never depends on mem_gnt.
    assign sb.st_ready = !full;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld_q  <= '0;
        end else begin
            if (pop) begin
                rd_ptr        <= rd_ptr + (PW+1)'(1);
                vld_q[rd_idx] <= 1'b0;
            end
            if (push) begin
                wr_ptr        <= wr_ptr + (PW+1)'(1);
                vld_q[wr_idx] <= 1'b1;
            end
        end
    end

    // Payload needs no reset: every output that exposes it is masked by the valid state.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_idx]  <= st_tag;
            data_q[wr_idx] <= sb.st_data;
            strb_q[wr_idx] <= sb.st_wstrb;
        end
`ifdef STORE_BUF_COALESCE_EN
        else if (merge) begin
            data_q[last_idx] <= merged;
            strb_q[last_idx] <= strb_q[last_idx] | sb.st_wstrb;
        end
`endif
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        assign hit[i] = vld_q[i] && tag_q[i] == ld_tag;
    end

    assign sb.ld_stall  = sb.ld_valid && |hit;
    assign sb.mem_req   = !empty;
    assign sb.mem_addr  = empty ? '0 : {tag_q[rd_idx], 2'b00};
    assign sb.mem_wdata = empty ? '0 : data_q[rd_idx];
    assign sb.mem_wstrb = empty ? '0 : strb_q[rd_idx];
    assign sb.empty     = empty;
    assign sb.count     = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer (works with or without STORE_BUF_COALESCE_EN)
module tb_store_buffer;
    localparam int DEPTH = 4;
`ifdef STORE_BUF_COALESCE_EN
    localparam int COAL_CNT = 1;
`else
    localparam int COAL_CNT = 2;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    ent_t mq[$];

    store_buffer_if #(.ADDR_W(32), .DEPTH(DEPTH)) sbi ();
    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .sb(sbi));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compares one cycle against the queue model, then advances both across the edge.
    task automatic step();
        logic        pop;
        logic        merge;
        logic        stall;
        logic        acc;
        logic [31:0] na;
        logic [31:0] nd;
        logic [3:0]  ns;
        ent_t        e;
        #3;
        pop   = mq.size() != 0 && sbi.mem_gnt;
        merge = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
        if (sbi.st_valid && mq.size() != 0 && mq[mq.size()-1].a[31:2] == sbi.st_addr[31:2] &&
            !(pop && mq.size() == 1))
            merge = 1'b1;
`endif
        stall = 1'b0;
        foreach (mq[i]) if (sbi.ld_valid && mq[i].a[31:2] == sbi.ld_addr[31:2]) stall = 1'b1;
        check("st_ready", 32'(sbi.st_ready), 32'(mq.size() < DEPTH || merge));
        check("mem_req", 32'(sbi.mem_req), 32'(mq.size() != 0));
        check("count", 32'(sbi.count), 32'(mq.size()));
        check("empty", 32'(sbi.empty), 32'(mq.size() == 0));
        check("ld_stall", 32'(sbi.ld_stall), 32'(stall));
        if (mq.size() != 0) e = mq[0];
        else e = '{a: 32'h0, d: 32'h0, s: 4'h0};
        check("mem_addr", sbi.mem_addr, {e.a[31:2], 2'b00});
        check("mem_wdata", sbi.mem_wdata, e.d);
        check("mem_wstrb", 32'(sbi.mem_wstrb), 32'(e.s));
        acc = sbi.st_valid && (mq.size() < DEPTH || merge);
        na  = sbi.st_addr;
        nd  = sbi.st_data;
        ns  = sbi.st_wstrb;
        @(posedge clk);
        if (pop) e = mq.pop_front();
        if (merge) begin
            e = mq[mq.size()-1];
            for (int b = 0; b < 4; b++) if (ns[b]) e.d[8*b +: 8] = nd[8*b +: 8];
            e.s = e.s | ns;
            mq[mq.size()-1] = e;
        end else if (acc) begin
            mq.push_back('{a: na, d: nd, s: ns});
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic g, input logic lv, input logic [31:0] la);
        sbi.st_valid = v;
        sbi.st_addr  = a;
        sbi.st_data  = d;
        sbi.st_wstrb = s;
        sbi.mem_gnt  = g;
        sbi.ld_valid = lv;
        sbi.ld_addr  = la;
        step();
    endtask

    initial begin
        sbi.st_valid = 1'b0;
        sbi.st_addr  = '0;
        sbi.st_data  = '0;
        sbi.st_wstrb = '0;
        sbi.mem_gnt  = 1'b0;
        sbi.ld_valid = 1'b1;
        sbi.ld_addr  = '0;
        #12;
        check("rst_ready", 32'(sbi.st_ready), 32'd1);
        check("rst_req", 32'(sbi.mem_req), 32'd0);
        check("rst_stall", 32'(sbi.ld_stall), 32'd0);
        check("rst_empty", 32'(sbi.empty), 32'd1);
        check("rst_count", 32'(sbi.count), 32'd0);
        check("rst_addr", sbi.mem_addr, 32'd0);
        check("rst_wdata", sbi.mem_wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single store with grant held: nothing issued while empty, request next cycle.
        drive(1, 32'h100, 32'hDEADBEEF, 4'hF, 1, 0, 0);
        check("lat_req", 32'(sbi.mem_req), 32'd1);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Fill, hold a fifth store, pop one, then drain in order.
        for (int i = 0; i < 4; i++) drive(1, 32'h1000 + 32'(i) * 16, 32'hA0 + 32'(i), 4'hF, 0, 0, 0);
        drive(1, 32'h1040, 32'hA4, 4'hF, 0, 0, 0);
        drive(1, 32'h1040, 32'hA4, 4'hF, 1, 0, 0);
        drive(1, 32'h1040, 32'hA4, 4'hF, 0, 0, 0);
        repeat (5) drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Load hazard on the same word, stall persists through the popping cycle.
        drive(1, 32'h203, 32'h55000000, 4'h8, 0, 1, 32'h200);
        drive(0, 0, 0, 0, 0, 1, 32'h200);
        drive(0, 0, 0, 0, 0, 1, 32'h204);
        drive(0, 0, 0, 0, 1, 1, 32'h200);
        drive(0, 0, 0, 0, 0, 1, 32'h200);

        // Two byte stores to one word: merged only when coalescing is built in.
        drive(1, 32'h300, 32'h11, 4'h1, 0, 0, 0);
        drive(1, 32'h301, 32'h2200, 4'h2, 0, 0, 0);
        check("coal_cnt", 32'(sbi.count), 32'(COAL_CNT));
        repeat (3) drive(0, 0, 0, 0, 1, 0, 0);

        // Random traffic over a small address window to exercise hits, wrap and merges.
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 1)), 32'h400 + 32'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(1, 15)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 32'h400 + 32'($urandom_range(0, 15)));
        repeat (6) drive(0, 0, 0, 0, 1, 0, 0);

        // Reset in the middle of a drain with three entries pending.
        for (int i = 0; i < 3; i++) drive(1, 32'h2000 + 32'(i) * 4, 32'hC0 + 32'(i), 4'hF, 0, 0, 0);
        sbi.st_valid = 1'b0;
        sbi.mem_gnt  = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(sbi.mem_req), 32'd0);
        check("mid_rst_empty", 32'(sbi.empty), 32'd1);
        check("mid_rst_count", 32'(sbi.count), 32'd0);
        check("mid_rst_addr", sbi.mem_addr, 32'd0);
        mq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, 0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
